rocc_multi_accumulator: RTL and testbench

//  Parametrised RoCC accelerator holding NUM_ACC accumulators. Ops: write, read, add,

---
 rtl/rocc_multi_accumulator.sv | 236 +++++++++++++++++++++++
 tb/tb_rocc_multi_accumulator.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rocc_multi_accumulator.sv
// RoCC accumulator bank: single-cycle write/read/add/clear, multi-cycle shift-add MAC,
// optional signed saturation and a ready/valid response FIFO.
module rocc_multi_accumulator #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned NUM_ACC    = 4,
  parameter int unsigned RESP_DEPTH = 2,
  parameter int unsigned MAC_BITS   = 1,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rocc_cmd_valid,
  output logic            rocc_cmd_ready,
  input  logic [6:0]      rocc_cmd_bits_inst_funct,
  input  logic [4:0]      rocc_cmd_bits_inst_rd,
  input  logic            rocc_cmd_bits_inst_xd,
  input  logic [XLEN-1:0] rocc_cmd_bits_rs1,
  input  logic [XLEN-1:0] rocc_cmd_bits_rs2,
  output logic            rocc_resp_valid,
  input  logic            rocc_resp_ready,
  output logic [4:0]      rocc_resp_bits_rd,
  output logic [XLEN-1:0] rocc_resp_bits_data,
  output logic            rocc_busy,
  output logic            rocc_interrupt,
  input  logic            rocc_exception
);

  localparam int unsigned IW        = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int unsigned MacCycles = XLEN / MAC_BITS;
  localparam int unsigned CW        = (MacCycles > 1) ? $clog2(MacCycles) : 1;
  localparam int unsigned PW        = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned NW        = $clog2(RESP_DEPTH + 1);

  localparam logic [2:0] OpWrite = 3'd0;
  localparam logic [2:0] OpRead  = 3'd1;
  localparam logic [2:0] OpAdd   = 3'd2;
  localparam logic [2:0] OpMac   = 3'd3;
  localparam logic [2:0] OpClear = 3'd4;

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e          state_q;
  logic [XLEN-1:0] acc_q [NUM_ACC];
  logic            irq_q;
  logic [XLEN-1:0] mac_a_q;
  logic [XLEN-1:0] mac_b_q;
  logic [XLEN-1:0] mac_tmp_q;
  logic [CW-1:0]   mac_cnt_q;
  logic [IW-1:0]   mac_idx_q;
  logic [4:0]      mac_rd_q;
  logic            mac_xd_q;

  logic [4:0]      fifo_rd_q   [RESP_DEPTH];
  logic [XLEN-1:0] fifo_data_q [RESP_DEPTH];
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [NW-1:0]   count_q;

  function automatic logic [XLEN+1:0] sext(input logic [XLEN-1:0] v);
    return {{2{v[XLEN-1]}}, v};
  endfunction

  // Sum of up to three XLEN-bit signed values fits XLEN+2 bits; overflow when the top three
  // bits disagree.
  function automatic logic [XLEN-1:0] clamp(input logic [XLEN+1:0] sum);
    logic [2:0] top;
    top = sum[XLEN+1:XLEN-1];
    if (SATURATE && (top != 3'b000) && (top != 3'b111)) begin
      return sum[XLEN+1] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
    end
    return sum[XLEN-1:0];
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [2:0]      cmd_op;
  logic [3:0]      cmd_idx_raw;
  logic [IW-1:0]   cmd_idx;
  logic            cmd_legal;
  logic            fifo_full;
  logic            cmd_ready_int;
  logic            cmd_take;
  logic            done_commit;
  logic [XLEN-1:0] acc_sel;
  logic [XLEN-1:0] acc_mac;
  logic [XLEN-1:0] add_res;
  logic [XLEN-1:0] mac_res;
  logic [XLEN-1:0] mac_step;
  logic            push_en;
  logic [4:0]      push_rd;
  logic [XLEN-1:0] push_data;
  logic            pop;

  assign cmd_op        = rocc_cmd_bits_inst_funct[2:0];
  assign cmd_idx_raw   = rocc_cmd_bits_inst_funct[6:3];
  assign cmd_idx       = cmd_idx_raw[IW-1:0];
  assign cmd_legal     = (cmd_op <= OpClear) && (32'(cmd_idx_raw) < NUM_ACC);
  assign fifo_full     = (count_q == NW'(RESP_DEPTH));
  assign cmd_ready_int = (state_q == StIdle) && !fifo_full;
  // A command accepted alongside an exception is swallowed without side effects.
  assign cmd_take      = !reset && rocc_cmd_valid && cmd_ready_int && !rocc_exception;
  assign done_commit   = (state_q == StDone) && (!mac_xd_q || !fifo_full) && !rocc_exception;

  assign acc_sel  = acc_q[cmd_idx];
  assign acc_mac  = acc_q[mac_idx_q];
  assign add_res  = clamp(sext(acc_sel) + sext(rocc_cmd_bits_rs1) + sext(rocc_cmd_bits_rs2));
  assign mac_res  = clamp(sext(acc_mac) + sext(mac_tmp_q));
  assign mac_step = mac_tmp_q + mac_a_q * XLEN'(mac_b_q[MAC_BITS-1:0]);

  always_comb begin
    push_en   = 1'b0;
    push_rd   = rocc_cmd_bits_inst_rd;
    push_data = '0;
    if (cmd_take && cmd_legal && (cmd_op != OpMac)) begin
      push_en = rocc_cmd_bits_inst_xd;
      case (cmd_op)
        OpWrite, OpRead: push_data = acc_sel;
        OpAdd:           push_data = add_res;
        default:         push_data = '0;
      endcase
    end else if (done_commit) begin
      push_en   = mac_xd_q;
      push_rd   = mac_rd_q;
      push_data = mac_res;
    end
  end

  assign pop = rocc_resp_valid && rocc_resp_ready;

  // Control FSM and MAC datapath.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      mac_a_q   <= '0;
      mac_b_q   <= '0;
      mac_tmp_q <= '0;
      mac_cnt_q <= '0;
      mac_idx_q <= '0;
      mac_rd_q  <= '0;
      mac_xd_q  <= 1'b0;
    end else if (rocc_exception) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_take && cmd_legal && (cmd_op == OpMac)) begin
            state_q   <= StMac;
            mac_a_q   <= rocc_cmd_bits_rs1;
            mac_b_q   <= rocc_cmd_bits_rs2;
            mac_tmp_q <= '0;
            mac_cnt_q <= CW'(MacCycles - 1);
            mac_idx_q <= cmd_idx;
            mac_rd_q  <= rocc_cmd_bits_inst_rd;
            mac_xd_q  <= rocc_cmd_bits_inst_xd;
          end
        end
        StMac: begin
          mac_tmp_q <= mac_step;
          mac_a_q   <= mac_a_q << MAC_BITS;
          mac_b_q   <= mac_b_q >> MAC_BITS;
          if (mac_cnt_q == '0) begin
            state_q <= StDone;
          end else begin
            mac_cnt_q <= mac_cnt_q - 1'b1;
          end
        end
        StDone: begin
          if (done_commit) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        acc_q[i] <= '0;
      end
      irq_q <= 1'b0;
    end else if (cmd_take) begin
      if (!cmd_legal) begin
        irq_q <= 1'b1;
      end else begin
        case (cmd_op)
          OpWrite: acc_q[cmd_idx] <= rocc_cmd_bits_rs1;
          OpAdd:   acc_q[cmd_idx] <= add_res;
          OpClear: begin
            for (int i = 0; i < NUM_ACC; i++) begin
              acc_q[i] <= '0;
            end
            irq_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end else if (done_commit) begin
      acc_q[mac_idx_q] <= mac_res;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || rocc_exception) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) begin
        tail_q <= ptr_inc(tail_q);
      end
      if (pop) begin
        head_q <= ptr_inc(head_q);
      end
      count_q <= count_q + NW'(push_en) - NW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push_en && !reset) begin
      fifo_rd_q[tail_q]   <= push_rd;
      fifo_data_q[tail_q] <= push_data;
    end
  end

  assign rocc_cmd_ready      = !reset && cmd_ready_int;
  assign rocc_resp_valid     = !reset && (count_q != '0);
  assign rocc_resp_bits_rd   = reset ? '0 : fifo_rd_q[head_q];
  assign rocc_resp_bits_data = reset ? '0 : fifo_data_q[head_q];
  assign rocc_busy           = !reset && ((state_q != StIdle) || (count_q != '0));
  assign rocc_interrupt      = !reset && irq_q;

endmodule

// File: tb/tb_rocc_multi_accumulator.sv
// Scoreboard bench: one wrapping and one saturating instance share stimulus; a reference
// model predicts responses and a negedge monitor checks them in order.
module tb_rocc_multi_accumulator;
  localparam int NUM_ACC = 4;
  localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [2:0] OP_WRITE = 3'd0, OP_READ = 3'd1, OP_ADD = 3'd2, OP_MAC = 3'd3,
                         OP_CLEAR = 3'd4;

  logic        clock = 1'b0;
  logic        reset, cmd_valid, xd, resp_ready, exception;
  logic [6:0]  funct;
  logic [4:0]  rd;
  logic [63:0] rs1, rs2;
  logic [1:0]  cmd_ready, resp_valid, busy, intr;
  logic [4:0]  resp_rd [2];
  logic [63:0] resp_data [2];

  int checks = 0, errors = 0, n, busy_lo;
  bit rand_ready = 0;
  logic [63:0] m_acc [2][NUM_ACC];
  logic [63:0] saved [2][NUM_ACC];
  bit          m_int;
  logic [68:0] exp_q0 [$];
  logic [68:0] exp_q1 [$];
  logic [2:0]  r_op;
  logic [3:0]  r_idx;
  logic [4:0]  r_rd;
  logic        r_xd;

  always #5 clock = ~clock;

  rocc_multi_accumulator #(.XLEN(64), .NUM_ACC(NUM_ACC), .RESP_DEPTH(2), .MAC_BITS(1),
                           .SATURATE(1'b0)) u_wrap (
    .clock(clock), .reset(reset), .rocc_cmd_valid(cmd_valid), .rocc_cmd_ready(cmd_ready[0]),
    .rocc_cmd_bits_inst_funct(funct), .rocc_cmd_bits_inst_rd(rd), .rocc_cmd_bits_inst_xd(xd),
    .rocc_cmd_bits_rs1(rs1), .rocc_cmd_bits_rs2(rs2), .rocc_resp_valid(resp_valid[0]),
    .rocc_resp_ready(resp_ready), .rocc_resp_bits_rd(resp_rd[0]),
    .rocc_resp_bits_data(resp_data[0]), .rocc_busy(busy[0]), .rocc_interrupt(intr[0]),
    .rocc_exception(exception)
  );

  rocc_multi_accumulator #(.XLEN(64), .NUM_ACC(NUM_ACC), .RESP_DEPTH(2), .MAC_BITS(1),
                           .SATURATE(1'b1)) u_sat (
    .clock(clock), .reset(reset), .rocc_cmd_valid(cmd_valid), .rocc_cmd_ready(cmd_ready[1]),
    .rocc_cmd_bits_inst_funct(funct), .rocc_cmd_bits_inst_rd(rd), .rocc_cmd_bits_inst_xd(xd),
    .rocc_cmd_bits_rs1(rs1), .rocc_cmd_bits_rs2(rs2), .rocc_resp_valid(resp_valid[1]),
    .rocc_resp_ready(resp_ready), .rocc_resp_bits_rd(resp_rd[1]),
    .rocc_resp_bits_data(resp_data[1]), .rocc_busy(busy[1]), .rocc_interrupt(intr[1]),
    .rocc_exception(exception)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Signed three-operand sum, optionally clamped to the signed 64-bit range.
  function automatic logic [63:0] add3(input logic [63:0] x, input logic [63:0] y,
                                       input logic [63:0] z, input bit sat);
    logic signed [65:0] s, smax, smin;
    smax = (66'sd1 <<< 63) - 66'sd1;
    smin = -(66'sd1 <<< 63);
    s = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y}) + $signed({{2{z[63]}}, z});
    if (sat && s > smax) return MAXV;
    if (sat && s < smin) return MINV;
    return s[63:0];
  endfunction

  task automatic model_apply(input logic [2:0] op, input logic [3:0] idx, input logic [4:0] dst,
                             input logic want, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    int i;
    i = int'(idx);
    if (op > 3'd4 || i >= NUM_ACC) begin
      m_int = 1;
      return;
    end
    for (int d = 0; d < 2; d++) begin
      r = '0;
      case (op)
        OP_WRITE: begin r = m_acc[d][i]; m_acc[d][i] = a; end
        OP_READ:  r = m_acc[d][i];
        OP_ADD:   begin r = add3(m_acc[d][i], a, b, d == 1); m_acc[d][i] = r; end
        OP_MAC:   begin r = add3(m_acc[d][i], a * b, 64'd0, d == 1); m_acc[d][i] = r; end
        default:  for (int k = 0; k < NUM_ACC; k++) m_acc[d][k] = '0;
      endcase
      if (want) begin
        if (d == 0) exp_q0.push_back({dst, r});
        else exp_q1.push_back({dst, r});
      end
    end
    if (op == OP_CLEAR) m_int = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] idx, input logic [4:0] dst,
                       input logic want, input logic [63:0] a, input logic [63:0] b);
    bit done;
    done = 0;
    @(posedge clock); #1;
    cmd_valid = 1; funct = {idx, op}; rd = dst; xd = want; rs1 = a; rs2 = b;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clock);
      if (cmd_ready[0]) begin
        model_apply(op, idx, dst, want, a, b);
        done = 1;
      end
      @(posedge clock); #1;
    end
    cmd_valid = 0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout: got no ready want ready (op=%0d)", op);
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && i < 600) begin
      @(negedge clock);
      i++;
    end
    check("drain_pending", exp_q0.size() + exp_q1.size(), 0);
  endtask

  task automatic mon(input int d, input logic [68:0] got);
    logic [68:0] want;
    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
      checks++; errors++;
      $display("FAIL resp%0d_unexpected: got %0h want none", d, got);
      return;
    end
    want = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    check(d == 0 ? "resp_wrap" : "resp_sat", got, want);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (resp_valid[0] && resp_ready) mon(0, {resp_rd[0], resp_data[0]});
      if (resp_valid[1] && resp_ready) mon(1, {resp_rd[1], resp_data[1]});
    end
  end

  always @(posedge clock) begin
    #2;
    if (rand_ready) resp_ready = ($urandom_range(0, 3) != 0);
  end

  function automatic logic [63:0] rval();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return MAXV;
      4: return MINV;
      5: return 64'($urandom_range(0, 1000));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1; cmd_valid = 0; funct = '0; rd = '0; xd = 0; rs1 = '0; rs2 = '0;
    resp_ready = 0; exception = 0; m_int = 0;
    for (int d = 0; d < 2; d++) for (int k = 0; k < NUM_ACC; k++) m_acc[d][k] = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_cmd_ready", cmd_ready, 2'b00);
    check("reset_resp_valid", resp_valid, 2'b00);
    check("reset_busy", busy, 2'b00);
    check("reset_interrupt", intr, 2'b00);
    @(posedge clock); #1 reset = 0;
    @(negedge clock);
    check("ready_after_reset", cmd_ready, 2'b11);
    @(posedge clock); #1 resp_ready = 1;

    // WRITE then 3-operand ADD; response one cycle after accept
    issue(OP_WRITE, 4'd2, 5'd0, 1'b0, 64'd5, 64'd0);
    issue(OP_ADD, 4'd2, 5'd7, 1'b1, 64'd3, 64'd4);
    @(negedge clock);
    check("add_resp_latency", resp_valid, 2'b11);
    check("add_resp_value", {resp_rd[0], resp_data[0]}, {5'd7, 64'd12});

    // MAC: 64 shift cycles plus one commit cycle with cmd_ready low
    issue(OP_WRITE, 4'd0, 5'd0, 1'b0, 64'd10, 64'd0);
    issue(OP_MAC, 4'd0, 5'd3, 1'b1, 64'd7, 64'd6);
    n = 0; busy_lo = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (cmd_ready[0]) break;
      n++;
      if (!busy[0]) busy_lo++;
    end
    check("mac_blocked_cycles", n, 65);
    check("mac_busy_low_cycles", busy_lo, 0);
    check("mac_resp_value", {resp_rd[0], resp_data[0]}, {5'd3, 64'd52});

    // Backpressure: two READs fill the FIFO, third waits for release
    @(posedge clock); #1 resp_ready = 0;
    issue(OP_READ, 4'd0, 5'd1, 1'b1, 64'd0, 64'd0);
    issue(OP_READ, 4'd2, 5'd2, 1'b1, 64'd0, 64'd0);
    @(negedge clock);
    check("full_blocks_cmd", cmd_ready, 2'b00);
    check("full_busy", busy, 2'b11);
    fork
      issue(OP_READ, 4'd1, 5'd4, 1'b1, 64'd0, 64'd0);
      begin repeat (4) @(posedge clock); #1 resp_ready = 1; end
    join
    drain();

    // Saturation boundaries
    issue(OP_WRITE, 4'd1, 5'd0, 1'b0, MAXV, 64'd0);
    issue(OP_ADD, 4'd1, 5'd5, 1'b1, 64'd1, 64'd0);
    @(negedge clock);
    check("add_overflow_wrap", resp_data[0], MINV);
    check("add_overflow_sat", resp_data[1], MAXV);
    issue(OP_WRITE, 4'd3, 5'd0, 1'b0, MINV, 64'd0);
    issue(OP_ADD, 4'd3, 5'd6, 1'b1, '1, '1);
    issue(OP_MAC, 4'd1, 5'd8, 1'b1, MAXV, 64'd2);
    issue(OP_MAC, 4'd3, 5'd9, 1'b1, MINV, 64'd3);
    drain();

    // Exception mid-MAC discards the MAC and any in-flight response
    issue(OP_WRITE, 4'd0, 5'd0, 1'b0, 64'd10, 64'd0);
    saved = m_acc;
    issue(OP_MAC, 4'd0, 5'd9, 1'b1, 64'd7, 64'd6);
    repeat (19) @(posedge clock);
    #1 exception = 1;
    @(posedge clock); #1 exception = 0;
    m_acc = saved;
    exp_q0.delete(); exp_q1.delete();
    @(negedge clock);
    check("exc_busy", busy, 2'b00);
    check("exc_resp_valid", resp_valid, 2'b00);
    check("exc_cmd_ready", cmd_ready, 2'b11);
    // command coinciding with exception is dropped
    @(posedge clock); #1;
    cmd_valid = 1; funct = {4'd0, OP_ADD}; rd = 5'd10; xd = 1; rs1 = 64'd100; rs2 = 64'd0;
    exception = 1;
    @(negedge clock);
    check("exc_cmd_offered", cmd_ready, 2'b11);
    @(posedge clock); #1 cmd_valid = 0; exception = 0;
    @(negedge clock);
    check("exc_cmd_no_resp", resp_valid, 2'b00);
    issue(OP_READ, 4'd0, 5'd12, 1'b1, 64'd0, 64'd0);
    drain();

    // Illegal commands raise the sticky interrupt; CLEAR drops it
    issue(3'd5, 4'd4, 5'd13, 1'b1, 64'd1, 64'd1);
    @(negedge clock);
    check("illegal_op_irq", intr, 2'b11);
    check("illegal_op_no_resp", resp_valid, 2'b00);
    issue(OP_CLEAR, 4'd0, 5'd11, 1'b1, 64'd0, 64'd0);
    @(negedge clock);
    check("clear_irq", intr, 2'b00);
    issue(OP_READ, 4'd5, 5'd14, 1'b1, 64'd0, 64'd0);
    @(negedge clock);
    check("illegal_idx_irq", intr, 2'b11);
    check("illegal_idx_no_resp", resp_valid, 2'b00);
    issue(OP_CLEAR, 4'd0, 5'd11, 1'b1, 64'd0, 64'd0);
    for (int k = 0; k < NUM_ACC; k++) issue(OP_READ, 4'(k), 5'(k), 1'b1, 64'd0, 64'd0);
    drain();

    // Randomized traffic with random response backpressure
    rand_ready = 1;
    for (int t = 0; t < 250; t++) begin
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4:     r_op = OP_WRITE;
        5, 6, 7, 8:        r_op = OP_READ;
        9, 10, 11, 12, 13: r_op = OP_ADD;
        14, 15, 16, 17:    r_op = OP_MAC;
        18:                r_op = OP_CLEAR;
        default:           r_op = 3'($urandom_range(5, 7));
      endcase
      r_idx = 4'($urandom_range(0, NUM_ACC - 1));
      if ($urandom_range(0, 15) == 0) r_idx = 4'($urandom_range(NUM_ACC, 15));
      r_rd = 5'($urandom_range(0, 31));
      r_xd = 1'($urandom_range(0, 1));
      issue(r_op, r_idx, r_rd, r_xd, rval(), rval());
      @(negedge clock);
      check("irq_model", intr, {m_int, m_int});
    end
    rand_ready = 0;
    @(posedge clock); #1 resp_ready = 1;
    drain();
    repeat (3) @(negedge clock);
    check("final_idle", busy, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
